// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - payload handshake between the TX FIFO and the UART transmitter
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_data_valid_i;
    logic                 tx_data_ready_o;

    modport master (
        output tx_data_i,
        output tx_data_valid_i,
        input  tx_data_ready_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_data_valid_i,
        output tx_data_ready_o
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits
module uart_tx #(
    parameter int CLK_DIV_WIDTH = 32,
    parameter int DATA_BITS     = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic                     en_i,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
    input  logic                     parity_en_i,
    input  logic                     parity_odd_i,
    input  logic                     stop2_i,
    uart_tx_if.slave                 bus,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     tx_done_o
);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE = CLK_DIV_WIDTH'(1);
    localparam logic [BIT_W-1:0]         BIT_ONE = BIT_W'(1);
    localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                   r_state, w_state_next;
    logic [DATA_BITS-1:0]     r_data;
    logic [CLK_DIV_WIDTH-1:0] r_div;
    logic [CLK_DIV_WIDTH-1:0] r_baud_cnt, w_baud_next;
    logic [CLK_DIV_WIDTH-1:0] w_div_in;
    logic [BIT_W-1:0]         r_bit_cnt, w_bit_next;
    logic                     r_par_en, r_par_odd, r_stop2;
    logic                     r_tx, w_tx_next;
    logic                     r_done, w_done_next;
    logic                     w_ready, w_accept, w_baud_zero, w_parity;
    logic [DATA_BITS-1:0]     w_shift;

    assign w_ready     = (r_state == IDLE) && en_i;
    assign w_accept    = bus.tx_data_valid_i && w_ready;
    assign w_div_in    = (clk_div_i == '0) ? DIV_ONE : clk_div_i;
    assign w_baud_zero = (r_baud_cnt == '0);
    assign w_parity    = (^r_data) ^ r_par_odd;

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit_cnt;
        w_baud_next  = r_baud_cnt;
        w_tx_next    = 1'b1;
        w_shift      = '0;

        // Every bit period is D cycles: count D-1 down to 0, reload at the boundary.
        if (r_state != IDLE) begin
            w_baud_next = w_baud_zero ? (r_div - DIV_ONE) : (r_baud_cnt - DIV_ONE);
        end

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = START;
                    w_bit_next   = '0;
                    w_baud_next  = w_div_in - DIV_ONE;
                end
            end
            START: begin
                if (w_baud_zero) begin
                    w_state_next = DATA;
                    w_bit_next   = '0;
                end
            end
            DATA: begin
                if (w_baud_zero) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = r_par_en ? PARITY : STOP;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_ONE;
                    end
                end
            end
            PARITY: begin
                if (w_baud_zero) begin
                    w_state_next = STOP;
                    w_bit_next   = '0;
                end
            end
            STOP: begin
                if (w_baud_zero) begin
                    if (r_bit_cnt == BIT_W'(r_stop2)) begin
                        w_state_next = IDLE;
                        w_bit_next   = '0;
                        w_baud_next  = '0;
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_ONE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // The line level is registered, so it is derived from where the FSM goes next.
        w_shift = r_data >> w_bit_next;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift[0];
            PARITY:  w_tx_next = w_parity;
            default: w_tx_next = 1'b1;
        endcase

        w_done_next = (r_state == STOP) && (w_state_next == IDLE);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_data     <= '0;
            r_div      <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_next;
            r_baud_cnt <= w_baud_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
            if (w_accept) begin
                r_data    <= bus.tx_data_i;
                r_div     <= w_div_in;
                r_par_en  <= parity_en_i;
                r_par_odd <= parity_odd_i;
                r_stop2   <= stop2_i;
            end
        end
    end

    assign bus.tx_data_ready_o = w_ready;
    assign tx_o                = r_tx;
    assign busy_o              = (r_state != IDLE);
    assign tx_done_o           = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a per-cycle line-level scoreboard
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        arst_ni;
    logic        en;
    logic [31:0] clk_div;
    logic        pen, podd, s2;
    logic        tx, busy, done;

    uart_tx_if #(.DATA_BITS(8)) bus ();

    uart_tx #(.CLK_DIV_WIDTH(32), .DATA_BITS(8)) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .en_i         (en),
        .clk_div_i    (clk_div),
        .parity_en_i  (pen),
        .parity_odd_i (podd),
        .stop2_i      (s2),
        .bus          (bus),
        .tx_o         (tx),
        .busy_o       (busy),
        .tx_done_o    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one expected line level per clock cycle of every accepted frame.
    bit m_q[$];
    bit m_busy      = 1'b0;
    bit m_prev_busy = 1'b0;
    bit m_acc       = 1'b0;

    function automatic void push_frame(input logic [7:0] d, input logic [31:0] div,
                                       input logic pe, input logic po, input logic st2);
        int per;
        int ones;
        bit seq[$];
        per  = (div == 0) ? 1 : int'(div);
        ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            ones += int'(d[i]);
            seq.push_back(d[i]);
        end
        if (pe) seq.push_back(((ones % 2) == 1) ^ po);
        seq.push_back(1'b1);
        if (st2) seq.push_back(1'b1);
        for (int j = 0; j < seq.size(); j++)
            for (int k = 0; k < per; k++) m_q.push_back(seq[j]);
    endfunction

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (arst_ni && bus.tx_data_valid_i && en && !m_busy) begin
            m_acc = 1'b1;
            push_frame(bus.tx_data_i, clk_div, pen, podd, s2);
        end
    end

    always @(negedge clk) begin
        logic etx, ebusy, edone;
        if (!arst_ni) begin
            m_q.delete();
            m_prev_busy = 1'b0;
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        end else begin
            if (m_q.size() > 0) begin
                etx = m_q.pop_front();
                ebusy = 1'b1;
            end else begin
                etx = 1'b1;
                ebusy = 1'b0;
            end
            edone = !ebusy && m_prev_busy;
            m_prev_busy = ebusy;
        end
        m_busy = ebusy;
        check("sb_tx_o", 32'(tx), 32'(etx));
        check("sb_busy_o", 32'(busy), 32'(ebusy));
        check("sb_tx_done_o", 32'(done), 32'(edone));
        check("sb_ready", 32'(bus.tx_data_ready_o), 32'(!ebusy && en));
    end

    typedef struct {
        logic [7:0]  data;
        logic [31:0] div;
        logic        pen, podd, s2;
        int          nbits;
        logic [11:0] bits;
        int          period;
        int          cycles;
    } vec_t;

    vec_t tab[7];

    task automatic wait_accept(input string nm);
        int i;
        i = 0;
        while (i < 300) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
            i++;
        end
        check({nm, "_accept"}, 32'(i < 300), 32'd1);
    endtask

    task automatic measure_busy(output int len);
        len = 0;
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (!busy) break;
            len++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic        samp[$];
        logic [31:0] a;
        int          idx;
        @(posedge clk);
        #2;
        en = 1'b1; bus.tx_data_i = v.data; clk_div = v.div;
        pen = v.pen; podd = v.podd; s2 = v.s2;
        bus.tx_data_valid_i = 1'b1;
        wait_accept(nm);
        #1 bus.tx_data_valid_i = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            @(negedge clk);
            if (!busy) break;
            samp.push_back(tx);
        end
        check({nm, "_len"}, 32'(samp.size()), 32'(v.cycles));
        check({nm, "_done"}, 32'(done), 32'd1);
        for (int k = 0; k < v.nbits; k++) begin
            idx = k * v.period;
            a = (idx < samp.size()) ? 32'(samp[idx]) : 32'hDEAD;
            check($sformatf("%s_bit%0d", nm, k), a, 32'(v.bits[k]));
        end
    endtask

    initial begin
        int   len, len2, gap, cnt;
        vec_t v;

        tab[0] = '{8'hA5, 32'd4, 1'b0, 1'b0, 1'b0, 10, 12'({1'b1, 8'hA5, 1'b0}), 4, 40};
        tab[1] = '{8'h07, 32'd2, 1'b1, 1'b0, 1'b0, 11, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 2, 22};
        tab[2] = '{8'h07, 32'd2, 1'b1, 1'b1, 1'b0, 11, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 2, 22};
        tab[3] = '{8'h3C, 32'd0, 1'b0, 1'b0, 1'b0, 10, 12'({1'b1, 8'h3C, 1'b0}), 1, 10};
        tab[4] = '{8'h00, 32'd3, 1'b0, 1'b0, 1'b1, 11, 12'({2'b11, 8'h00, 1'b0}), 3, 33};
        tab[5] = '{8'hFF, 32'd3, 1'b1, 1'b1, 1'b1, 12, 12'({2'b11, 1'b1, 8'hFF, 1'b0}), 3, 36};
        tab[6] = '{8'h5A, 32'd1, 1'b1, 1'b0, 1'b1, 12, 12'({2'b11, 1'b0, 8'h5A, 1'b0}), 1, 12};

        arst_ni = 1'b0; en = 1'b0; clk_div = 32'd4; pen = 1'b0; podd = 1'b0; s2 = 1'b0;
        bus.tx_data_i = 8'h00; bus.tx_data_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", 32'(tx), 32'd1);
        check("rst_busy_o", 32'(busy), 32'd0);
        check("rst_tx_done_o", 32'(done), 32'd0);
        @(posedge clk);
        #2 arst_ni = 1'b1; en = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.tx_data_ready_o), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(tab[i], $sformatf("vec%0d", i));

        // en low blocks acceptance; dropping en mid-frame lets the frame finish.
        @(posedge clk);
        #2 en = 1'b0; clk_div = 32'd4; pen = 1'b0; s2 = 1'b0;
        bus.tx_data_i = 8'h55; bus.tx_data_valid_i = 1'b1;
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += int'(busy); end
        check("en_off_no_frame", 32'(cnt), 32'd0);
        #1 en = 1'b1;
        wait_accept("en_mid");
        len = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (!busy) break;
            len++;
            if (len == 5) #1 en = 1'b0;
        end
        check("en_mid_len", 32'(len), 32'd40);
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += int'(busy); end
        check("en_mid_no_new", 32'(cnt), 32'd0);
        #1 bus.tx_data_valid_i = 1'b0; en = 1'b1;

        // Back-to-back frames with two stop bits.
        @(posedge clk);
        #2 clk_div = 32'd3; pen = 1'b0; s2 = 1'b1;
        bus.tx_data_i = 8'h00; bus.tx_data_valid_i = 1'b1;
        wait_accept("b2b_first");
        #1 bus.tx_data_i = 8'hFF;
        measure_busy(len);
        check("b2b_len1", 32'(len), 32'd33);
        gap = 1;
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (busy) break;
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd1);
        #1 bus.tx_data_valid_i = 1'b0;
        measure_busy(len2);
        check("b2b_len2", 32'(len2 + 1), 32'd33);

        // Divisor change mid-frame only affects the next frame.
        @(posedge clk);
        #2 clk_div = 32'd4; s2 = 1'b0; bus.tx_data_i = 8'h96; bus.tx_data_valid_i = 1'b1;
        wait_accept("div_a");
        #1 bus.tx_data_valid_i = 1'b0; clk_div = 32'd8; bus.tx_data_i = 8'h00; pen = 1'b1;
        measure_busy(len);
        check("div_a_len", 32'(len), 32'd40);
        @(posedge clk);
        #2 pen = 1'b0; bus.tx_data_i = 8'h69; bus.tx_data_valid_i = 1'b1;
        wait_accept("div_b");
        #1 bus.tx_data_valid_i = 1'b0;
        measure_busy(len);
        check("div_b_len", 32'(len), 32'd80);

        // Asynchronous reset in the middle of the data bits.
        @(posedge clk);
        #2 clk_div = 32'd4; bus.tx_data_i = 8'h00; bus.tx_data_valid_i = 1'b1;
        wait_accept("rst_mid");
        #1 bus.tx_data_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #3 arst_ni = 1'b0;
        #1;
        check("rst_mid_tx_o", 32'(tx), 32'd1);
        check("rst_mid_busy_o", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2 arst_ni = 1'b1;
        v = '{8'h3C, 32'd2, 1'b0, 1'b0, 1'b0, 10, 12'({1'b1, 8'h3C, 1'b0}), 2, 20};
        run_vec(v, "rst_3c");

        // Random traffic, including mid-frame config changes, against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            bus.tx_data_valid_i = ($urandom_range(0, 3) != 0);
            bus.tx_data_i = 8'($urandom);
            clk_div = 32'($urandom_range(0, 4));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 9) != 0);
        end
        #1 bus.tx_data_valid_i = 1'b0; en = 1'b1;
        measure_busy(len);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 32, width of the baud divisor input.
REQ-002 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  transmitter enable; gates acceptance of new frames only.
REQ-006 SHALL have port clk_div_i  input  CLK_DIV_WIDTH  clk_i cycles per bit period.
REQ-007 SHALL have port parity_en_i  input  1  1 = parity bit is appended after the data bits.
REQ-008 SHALL have port parity_odd_i  input  1  1 = odd parity, 0 = even parity.
REQ-009 SHALL have port stop2_i  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 SHALL have port tx_data_i  input  DATA_BITS  frame payload from the TX FIFO.
REQ-011 SHALL have port tx_data_valid_i  input  1  payload valid.
REQ-012 SHALL have port tx_data_ready_o  output  1  block can accept a payload.
REQ-013 SHALL have port tx_o  output  1  serial line; idle high.
REQ-014 SHALL have port busy_o  output  1  frame in progress.
REQ-015 SHALL have port tx_done_o  output  1  single-cycle pulse at end of frame.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL drive tx_data_ready_o = (state == IDLE) && en_i, combinationally.
REQ-018 SHALL accept a payload on the rising edge where tx_data_valid_i && tx_data_ready_o, then enter START on the next cycle.
REQ-019 SHALL latch tx_data_i, clk_div_i, parity_en_i, parity_odd_i and stop2_i at acceptance; input changes mid-frame SHALL NOT affect the current frame.
REQ-020 SHALL treat a latched divisor of 0 as 1.
REQ-021 SHALL hold each bit on tx_o for exactly max(clk_div,1) clk_i cycles, counted by a down-counter reloaded at every bit boundary.
REQ-022 SHALL drive tx_o as follows: IDLE = 1, START = 0, DATA = data bits LSB first, PARITY = parity bit, STOP = 1.
REQ-023 SHALL leave DATA for PARITY after DATA_BITS bits when parity is enabled; otherwise it SHALL go from DATA directly to STOP.
REQ-024 SHALL compute the parity bit as the XOR of the latched data bits (even parity), inverted when parity_odd_i was latched as 1.
REQ-025 SHALL hold STOP for 1 or 2 bit periods per the latched stop2_i.
REQ-026 SHALL return from STOP to IDLE at the last cycle of the final stop period and pulse tx_done_o for exactly one cycle, the first IDLE cycle.
REQ-027 SHALL allow back-to-back frames: a payload valid in that first IDLE cycle SHALL be accepted, giving exactly one idle-high cycle between frames.
REQ-028 SHALL drive busy_o = (state != IDLE).
REQ-029 SHALL NOT abort an in-progress frame when en_i is deasserted; it only blocks the next acceptance.
REQ-030 SHALL use tx_o as a registered output with no combinational path from any input.
REQ-031 SHALL give a frame duration of (1 + DATA_BITS + parity_en + 1 + stop2) x max(clk_div,1) cycles, measured from the first START cycle to the first IDLE cycle.

Reset
REQ-032 SHALL, on arst_ni low at any time including mid-frame, immediately set state = IDLE, tx_o = 1, busy_o = 0, tx_done_o = 0, bit and baud counters = 0, and the latched payload and config = 0.
REQ-033 SHALL, with en_i = 1, drive tx_data_ready_o = 1 in the first cycle after reset release.

Verification
REQ-034 Bench SHALL cover: clk_div=4, no parity, 1 stop, data 0xA5 -> tx_o = 0 then 1,0,1,0,0,1,0,1 then 1, each bit held 4 cycles; 40 cycles total; tx_done_o pulses once.
REQ-035 Bench SHALL cover: clk_div=2, parity even, data 0x07 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame = 22 cycles.
REQ-036 Bench SHALL cover: stop2=1, clk_div=3, back-to-back valid payloads 0x00 and 0xFF -> two stop periods (6 cycles high) plus exactly 1 idle cycle between frames; both frames correct.
REQ-037 Bench SHALL cover: clk_div=0 -> bit period = 1 cycle; a change of clk_div_i from 4 to 8 mid-frame -> current frame keeps 4-cycle bits and the next frame uses 8.
REQ-038 Bench SHALL cover: arst_ni asserted during DATA -> tx_o = 1 and busy_o = 0 immediately; after release, a new payload 0x3C transmits correctly.
REQ-039 Bench SHALL cover: en_i=0 with valid=1 -> ready=0 and nothing sent; en_i dropped mid-frame -> frame completes and no new acceptance occurs.
